// File: rtl/led_pkg.sv
// led_pkg: timing constants and decoder state shared with the matrix driver.
package led_pkg;
    localparam int T0_CYCLES    = 20;
    localparam int T1_CYCLES    = 41;
    localparam int BIT_CYCLES   = 63;
    localparam int LATCH_CYCLES = 2400;
    localparam int WORD_BITS    = 24;

    typedef enum logic [1:0] {WAIT_LATCH, LOW, HIGH} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: async-reset two-flop synchronizer, output resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_ff;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_ff <= '0;
        else     r_ff <= {r_ff[0], i_d};

    assign o_q = r_ff[1];
endmodule

// File: rtl/led_stream_decoder.sv
// led_stream_decoder: recovers 24-bit pixel words from the pulse-width-encoded LED line.
module led_stream_decoder #(
    parameter int THRESH_CYCLES = 31,
    parameter int MIN_HIGH      = 6,
    parameter int MAX_HIGH      = 56,
    parameter int LATCH_CYCLES  = led_pkg::LATCH_CYCLES,
    parameter int WORD_BITS     = led_pkg::WORD_BITS,
    parameter int IDX_W         = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [WORD_BITS-1:0] word_data,
    output logic                 word_valid,
    output logic [IDX_W-1:0]     word_index,
    output logic                 frame_end,
    output logic                 bit_error
);
    import led_pkg::*;

    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam int BW = $clog2(WORD_BITS + 1);
    localparam logic [LW-1:0] LATCH = LW'(LATCH_CYCLES);
    localparam logic [6:0]    THR   = 7'(THRESH_CYCLES);
    localparam logic [6:0]    MINH  = 7'(MIN_HIGH);
    localparam logic [6:0]    MAXH  = 7'(MAX_HIGH);
    localparam logic [BW-1:0] LASTB = BW'(WORD_BITS - 1);

    logic                 w_rst_n, w_rst, w_din_s, w_bit;
    logic [6:0]           w_high_nx;
    logic [LW-1:0]        w_low_nx;
    state_t               r_state;
    logic [LW-1:0]        r_low;
    logic [6:0]           r_high;
    logic [BW-1:0]        r_bits;
    logic [WORD_BITS-1:0] r_shift, r_word_data;
    logic [IDX_W-1:0]     r_idx, r_word_index;
    logic                 r_got, r_word_valid, r_frame_end, r_bit_error;

    // Reset asserts asynchronously but releases two clocks later, in step with clk.
    sync_2ff u_rst_sync (.clk(clk), .rst(rst), .i_d(1'b1), .o_q(w_rst_n));
    assign w_rst = ~w_rst_n;
    sync_2ff u_din_sync (.clk(clk), .rst(w_rst), .i_d(din), .o_q(w_din_s));

    assign w_high_nx = (r_high == 7'h7f) ? r_high : r_high + 7'd1;
    assign w_low_nx  = (r_low == LATCH) ? r_low : r_low + LW'(1);
    assign w_bit     = r_high >= THR;

    // Run counters include the cycle that caused the state change, so they equal true run lengths.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_state      <= WAIT_LATCH;
            r_low        <= '0;
            r_high       <= '0;
            r_bits       <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_got        <= 1'b0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_word_index <= '0;
            r_frame_end  <= 1'b0;
            r_bit_error  <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_frame_end  <= 1'b0;
            r_bit_error  <= 1'b0;
            case (r_state)
                WAIT_LATCH:
                    if (w_din_s) r_low <= '0;
                    else begin
                        r_low <= w_low_nx;
                        if (w_low_nx == LATCH) begin
                            r_state <= LOW;
                            r_bits  <= '0;
                            r_idx   <= '0;
                            r_got   <= 1'b0;
                        end
                    end
                LOW:
                    if (w_din_s) begin
                        r_high  <= 7'd1;
                        r_state <= HIGH;
                    end else begin
                        r_low <= w_low_nx;
                        if (w_low_nx == LATCH && r_got) begin
                            r_frame_end <= 1'b1;
                            r_bit_error <= r_bits != '0;
                            r_bits      <= '0;
                            r_idx       <= '0;
                            r_got       <= 1'b0;
                        end
                    end
                HIGH:
                    if (w_din_s) begin
                        r_high <= w_high_nx;
                        if (w_high_nx > MAXH) begin
                            r_bit_error <= 1'b1;
                            r_bits      <= '0;
                            r_low       <= '0;
                            r_state     <= WAIT_LATCH;
                        end
                    end else if (r_high < MINH) begin
                        r_bit_error <= 1'b1;
                        r_bits      <= '0;
                        r_low       <= LW'(1);
                        r_state     <= WAIT_LATCH;
                    end else begin
                        r_shift <= {r_shift[WORD_BITS-2:0], w_bit};
                        r_low   <= LW'(1);
                        r_got   <= 1'b1;
                        r_state <= LOW;
                        if (r_bits == LASTB) begin
                            r_word_data  <= {r_shift[WORD_BITS-2:0], w_bit};
                            r_word_valid <= 1'b1;
                            r_word_index <= r_idx;
                            r_idx        <= r_idx + IDX_W'(1);
                            r_bits       <= '0;
                        end else r_bits <= r_bits + BW'(1);
                    end
                default: r_state <= WAIT_LATCH;
            endcase
        end
    end

    assign word_data  = r_word_data;
    assign word_valid = r_word_valid;
    assign word_index = r_word_index;
    assign frame_end  = r_frame_end;
    assign bit_error  = r_bit_error;
endmodule

// File: tb/tb_led_stream_decoder.sv
// tb_led_stream_decoder: directed LED-line stimulus with a queue-based output scoreboard.
module tb_led_stream_decoder;
    import led_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, din = 1'b0;
    logic [23:0] word_data;
    logic        word_valid, frame_end, bit_error;
    logic [5:0]  word_index;

    typedef struct {
        logic [2:0]  kind;
        logic [23:0] data;
        logic [5:0]  idx;
    } ev_t;

    ev_t q[$];
    int  total = 0, bad = 0;

    led_stream_decoder dut (
        .clk(clk), .rst(rst), .din(din),
        .word_data(word_data), .word_valid(word_valid), .word_index(word_index),
        .frame_end(frame_end), .bit_error(bit_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Event kind is {bit_error, frame_end, word_valid}.
    initial forever begin
        @(posedge clk);
        #1;
        if (word_valid || frame_end || bit_error) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got kind=%b data=%h idx=%0d, none expected",
                         {bit_error, frame_end, word_valid}, word_data, word_index);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("event_kind", {29'd0, bit_error, frame_end, word_valid}, {29'd0, e.kind});
                if (e.kind[0]) begin
                    chk("word_data", {8'd0, word_data}, {8'd0, e.data});
                    chk("word_index", {26'd0, word_index}, {26'd0, e.idx});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int h, input int l);
        din = 1'b1;
        tick(h);
        din = 1'b0;
        tick(l);
    endtask

    task automatic send_bit(input bit b);
        pulse(b ? T1_CYCLES : T0_CYCLES, BIT_CYCLES - (b ? T1_CYCLES : T0_CYCLES));
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic exp_word(input logic [23:0] w, input logic [5:0] idx);
        q.push_back('{3'b001, w, idx});
    endtask

    task automatic exp_ev(input logic [2:0] k);
        q.push_back('{k, 24'd0, 6'd0});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, {8'd0, word_data}, 32'd0);
        chk({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
        chk({tag, "_index"}, {26'd0, word_index}, 32'd0);
        chk({tag, "_frame_end"}, {31'd0, frame_end}, 32'd0);
        chk({tag, "_bit_error"}, {31'd0, bit_error}, 32'd0);
    endtask

    initial begin
        tick(3);
        chk_zero("reset");
        rst = 1'b0;
        tick(2500);
        exp_word(24'hFF0080, 0); send_word(24'hFF0080);
        exp_ev(3'b010); tick(2500);
        exp_word(24'h000001, 0); send_word(24'h000001);
        exp_word(24'h800000, 1); send_word(24'h800000);
        exp_word(24'h0F0F0F, 2); send_word(24'h0F0F0F);
        exp_ev(3'b010); tick(2500);
        exp_word(24'hABCDEF, 0); send_word(24'hABCDEF);
        exp_ev(3'b010); tick(2500);
        exp_word(24'hFFFFFD, 0);
        repeat (22) send_bit(1'b1);
        pulse(30, 33);
        pulse(31, 32);
        exp_word(24'h400000, 1);
        pulse(6, 57);
        pulse(56, 7);
        repeat (22) send_bit(1'b0);
        exp_ev(3'b100); pulse(5, 58);
        tick(2500);
        exp_ev(3'b100);
        din = 1'b1;
        tick(200);
        din = 1'b0;
        tick(30);
        send_word(24'h123456);
        tick(2500);
        exp_word(24'h654321, 0); send_word(24'h654321);
        exp_ev(3'b010); tick(2500);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(5);
        send_word(24'hAAAAAA);
        tick(2500);
        exp_ev(3'b110);
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        tick(2500);
        exp_word(24'h5A5A5A, 0); send_word(24'h5A5A5A);
        tick(5);
        chk("held_data", {8'd0, word_data}, 32'h5A5A5A);
        for (int i = 0; i < 12; i++) send_bit(i[1]);
        rst = 1'b1;
        #1;
        chk_zero("midword_rst");
        tick(3);
        rst = 1'b0;
        tick(5);
        send_word(24'hC3C3C3);
        tick(2500);
        chk("pending_events", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_stream_decoder.md
# led_stream_decoder

Single-wire LED-stream receiver: recovers pixel words from the pulse-width-encoded serial line that our matrix driver transmits (high time T0 = 20 clk for a 0, T1 = 41 clk for a 1, 63-clk bit period, long low = latch). It sits on the loopback/observation path, or in front of a downstream chain, and feeds decoded 24-bit words into the frame-checking logic. Output is a push-only stream with no backpressure, because the line cannot be stalled.

## Interface
- `THRESH_CYCLES`, 31: high run ≥ this decodes as 1, else 0.
- `MIN_HIGH`, 6: high run < this is a glitch (error).
- `MAX_HIGH`, 56: high run > this is a stuck line (error).
- `LATCH_CYCLES`, 2400: low run of this length ends a frame (50 µs at 48 MHz).
- `WORD_BITS`, 24: bits per pixel word, MSB first.
- `IDX_W`, 6: width of the word index (64-pixel matrix).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `din` in 1: raw serial line, asynchronous to `clk`.
- `word_data` out WORD_BITS: last complete word; held until the next one.
- `word_valid` out 1: one-cycle pulse per complete word.
- `word_index` out IDX_W: position of `word_data` within the current frame, wraps mod 2^IDX_W.
- `frame_end` out 1: one-cycle pulse when a latch gap completes after any received bit.
- `bit_error` out 1: one-cycle pulse on glitch, stuck-high or partial word at latch.

## Operation
- `din` passes through a 2-flop synchronizer (reset to 0), giving `din_s`. All decoding uses `din_s`.
- States:
  - WAIT_LATCH: entered on reset and after any error. Counts the low run and ignores high pulses. A high restarts the count. Goes to LOW when the count reaches LATCH_CYCLES; no `frame_end` pulse from this state.
  - LOW: counts the low run, saturating at LATCH_CYCLES.
    - `din_s`=1: clear the high counter and go to HIGH.
    - Low count reaches LATCH_CYCLES and a bit or word was received this frame:
      - Pulse `frame_end`.
      - If bit count ≠ 0, also pulse `bit_error` and discard the partial word.
      - Clear the bit count and word index; stay in LOW.
  - HIGH: counts high cycles (7-bit, saturating).
    - Count exceeds MAX_HIGH: pulse `bit_error` immediately, discard the partial word, go to WAIT_LATCH.
    - `din_s`=0 with count < MIN_HIGH: pulse `bit_error`, go to WAIT_LATCH.
    - Otherwise shift (count ≥ THRESH_CYCLES) into the shift register LSB, increment the bit count, clear the low counter, go to LOW.
    - On the WORD_BITS-th bit:
      - Load `word_data`, pulse `word_valid`, present the current index.
      - Then increment the index and clear the bit count.
- Low gaps shorter than LATCH_CYCLES between bits are legal at any length.
- After the first word of a frame, `word_index` is 0. The index is cleared only by a latch gap or reset.

## Timing
- Reset (async assert) values:
  - `word_data`=0, `word_valid`=0, `word_index`=0, `frame_end`=0, `bit_error`=0.
  - Counters are 0; state is WAIT_LATCH.
  - Reset deassertion is synchronized internally.
- All outputs are registered.
- Latency: `word_valid` asserts 3 `clk` edges after the final falling edge of `din` (2 synchronizer + 1 decode).
- High-run measurement is the number of cycles `din_s`=1; edges are accurate to ±1 cycle of pin jitter.
- `frame_end` asserts the cycle after the low count reaches LATCH_CYCLES, and asserts only once per gap.
- Simultaneous events: a final-bit decode and a latch cannot coincide, because the latch requires a long low run after the bit.
- `bit_error` and `frame_end` may pulse in the same cycle (partial word at latch).
- Reset mid-word discards everything; no pulse is emitted.

## Structure
- Shared package `led_pkg` holds:
  - Timing constants T0_CYCLES=20, T1_CYCLES=41, BIT_CYCLES=63, LATCH_CYCLES=2400, WORD_BITS=24, shared with the matrix driver.
  - The decoder state enum (WAIT_LATCH, LOW, HIGH).
- One sub-module, `sync_2ff`: the async-reset two-flop synchronizer for `din`.
- The FSM, counters and shift register stay in `led_stream_decoder`.

## Test plan
- Reset, 2400 low, then 24 encoded bits of 0xFF0080 -> one `word_valid` with `word_data`=0xFF0080, `word_index`=0, no `bit_error`.
- Three words (0x000001, 0x800000, 0x0F0F0F) then 2400 low -> valid pulses with index 0,1,2, a single `frame_end`; the next frame restarts at index 0.
- Threshold boundaries: high runs of 30 and 31 cycles -> bits 0 and 1. High runs of 5 -> `bit_error`; 6 -> valid 0.
- `din` stuck high -> `bit_error` after 57 high cycles. Words resume only after a full 2400-cycle low gap.
- Bits sent without the initial latch gap after reset -> no `word_valid`. 10 bits then a latch -> `bit_error` and `frame_end` in the same cycle, no word.
- Assert `rst` mid-word (after 12 bits) -> all outputs 0 immediately. A subsequent full 24-bit word without a preceding latch gap is ignored.
